// File: rtl/jtag_tap_multi_dr.sv
// jtag_tap_multi_dr: clk-oversampled 1149.1 TAP with BYPASS and user DRs.
// Define JTAG_IDCODE_EN to add the 32-bit IDCODE register (code 1).
module jtag_tap_multi_dr #(
  parameter int          IR_WIDTH    = 4,
  parameter int          DR_WIDTH    = 8,
  parameter int          NUM_USER_DR = 2,
  parameter logic [31:0] IDCODE_VAL  = 32'h1000_0001
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            tck,
  input  logic                            tms,
  input  logic                            tdi,
  output logic                            tdo,
  output logic                            tdo_oe,
  input  logic [NUM_USER_DR*DR_WIDTH-1:0] user_dr_in,
  output logic [NUM_USER_DR*DR_WIDTH-1:0] user_dr_out,
  output logic [NUM_USER_DR-1:0]          user_update,
  output logic [3:0]                      tap_state,
  output logic [IR_WIDTH-1:0]             ir_out
);

  typedef enum logic [3:0] {
    TLR    = 4'hF,
    RTI    = 4'hC,
    SEL_DR = 4'h7,
    CAP_DR = 4'h6,
    SH_DR  = 4'h2,
    EX1_DR = 4'h1,
    PA_DR  = 4'h3,
    EX2_DR = 4'h0,
    UPD_DR = 4'h5,
    SEL_IR = 4'h4,
    CAP_IR = 4'hE,
    SH_IR  = 4'hA,
    EX1_IR = 4'h9,
    PA_IR  = 4'hB,
    EX2_IR = 4'h8,
    UPD_IR = 4'hD
  } tap_t;

`ifdef JTAG_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] IR_RST = IR_WIDTH'(1);
`else
  localparam logic [IR_WIDTH-1:0] IR_RST = '1;
`endif

  tap_t state_q;
  tap_t state_d;

  logic [1:0] tck_sy;
  logic [1:0] tms_sy;
  logic [1:0] tdi_sy;
  logic       tck_d;
  logic       tck_rise;
  logic       tck_fall;
  logic       tms_s;
  logic       tdi_s;

  logic [IR_WIDTH-1:0] ir_sr;
  logic [DR_WIDTH-1:0] dr_sr;
  logic                byp;
  logic [31:0]         ir_ext;
  logic [31:0]         uidx;
  logic                user_hit;
  logic                dr_lsb;
`ifdef JTAG_IDCODE_EN
  logic [31:0]         id_sr;
  logic                id_sel;
`endif

  // two-flop synchronisers plus a delay flop for tck edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tck_sy <= '0;
      tms_sy <= '0;
      tdi_sy <= '0;
      tck_d  <= 1'b0;
    end else begin
      tck_sy <= {tck_sy[0], tck};
      tms_sy <= {tms_sy[0], tms};
      tdi_sy <= {tdi_sy[0], tdi};
      tck_d  <= tck_sy[1];
    end
  end

  assign tck_rise = tck_sy[1] & ~tck_d;
  assign tck_fall = ~tck_sy[1] & tck_d;
  assign tms_s    = tms_sy[1];
  assign tdi_s    = tdi_sy[1];

  // TAP state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= TLR;
    else     state_q <= state_d;
  end

  // 1149.1 next-state, advancing only on a tck rising edge
  always_comb begin
    state_d = state_q;
    if (tck_rise) begin
      case (state_q)
        TLR:     state_d = tms_s ? TLR    : RTI;
        RTI:     state_d = tms_s ? SEL_DR : RTI;
        SEL_DR:  state_d = tms_s ? SEL_IR : CAP_DR;
        CAP_DR:  state_d = tms_s ? EX1_DR : SH_DR;
        SH_DR:   state_d = tms_s ? EX1_DR : SH_DR;
        EX1_DR:  state_d = tms_s ? UPD_DR : PA_DR;
        PA_DR:   state_d = tms_s ? EX2_DR : PA_DR;
        EX2_DR:  state_d = tms_s ? UPD_DR : SH_DR;
        UPD_DR:  state_d = tms_s ? SEL_DR : RTI;
        SEL_IR:  state_d = tms_s ? TLR    : CAP_IR;
        CAP_IR:  state_d = tms_s ? EX1_IR : SH_IR;
        SH_IR:   state_d = tms_s ? EX1_IR : SH_IR;
        EX1_IR:  state_d = tms_s ? UPD_IR : PA_IR;
        PA_IR:   state_d = tms_s ? EX2_IR : PA_IR;
        EX2_IR:  state_d = tms_s ? UPD_IR : SH_IR;
        UPD_IR:  state_d = tms_s ? SEL_DR : RTI;
        default: state_d = TLR;
      endcase
    end
  end

  assign tap_state = state_q;

  // instruction decode; codes outside IDCODE/USERi fall back to BYPASS
  assign ir_ext   = 32'(ir_out);
  assign uidx     = ir_ext - 32'd2;
  assign user_hit = (ir_ext >= 32'd2) &&
                    (ir_ext < 32'(NUM_USER_DR + 2));
`ifdef JTAG_IDCODE_EN
  assign id_sel   = (ir_out == IR_WIDTH'(1));
`endif

  // serial output bit of the selected data register
  always_comb begin
    dr_lsb = byp;
    if (user_hit) dr_lsb = dr_sr[0];
`ifdef JTAG_IDCODE_EN
    if (id_sel) dr_lsb = id_sr[0];
`endif
  end

  // capture and shift of IR and DR shift registers on tck rise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_sr <= '0;
      dr_sr <= '0;
      byp   <= 1'b0;
`ifdef JTAG_IDCODE_EN
      id_sr <= '0;
`endif
    end else if (state_q == TLR) begin
      ir_sr <= '0;
      dr_sr <= '0;
      byp   <= 1'b0;
`ifdef JTAG_IDCODE_EN
      id_sr <= '0;
`endif
    end else if (tck_rise) begin
      case (state_q)
        CAP_IR: ir_sr <= IR_WIDTH'(1);
        SH_IR:  ir_sr <= {tdi_s, ir_sr[IR_WIDTH-1:1]};
        CAP_DR: begin
          if (user_hit)
            dr_sr <= user_dr_in[uidx*DR_WIDTH +: DR_WIDTH];
`ifdef JTAG_IDCODE_EN
          else if (id_sel)
            id_sr <= IDCODE_VAL;
`endif
          else
            byp <= 1'b0;
        end
        SH_DR: begin
          if (user_hit)
            dr_sr <= (dr_sr >> 1) |
                     (DR_WIDTH'(tdi_s) << (DR_WIDTH - 1));
`ifdef JTAG_IDCODE_EN
          else if (id_sel)
            id_sr <= {tdi_s, id_sr[31:1]};
`endif
          else
            byp <= tdi_s;
        end
        default: ;
      endcase
    end
  end

  // tck-fall side: tdo, tdo_oe, IR update, user DR update pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tdo         <= 1'b0;
      tdo_oe      <= 1'b0;
      ir_out      <= IR_RST;
      user_dr_out <= '0;
      user_update <= '0;
    end else begin
      user_update <= '0;
      if (state_q == TLR) ir_out <= IR_RST;
      if (tck_fall) begin
        tdo_oe <= (state_q == SH_DR) || (state_q == SH_IR);
        if (state_q == SH_IR)      tdo <= ir_sr[0];
        else if (state_q == SH_DR) tdo <= dr_lsb;
        if (state_q == UPD_IR) ir_out <= ir_sr;
        if (state_q == UPD_DR && user_hit) begin
          for (int i = 0; i < NUM_USER_DR; i++) begin
            if (uidx == 32'(i)) begin
              user_dr_out[i*DR_WIDTH +: DR_WIDTH] <= dr_sr;
              user_update[i] <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_tap_multi_dr.sv
// tb_jtag_tap_multi_dr: scoreboard bench for jtag_tap_multi_dr.
// Expected tdo bits are queued as stimulus is driven, popped on sampling.
module tb_jtag_tap_multi_dr;
  localparam int IRW = 4;
  localparam int DRW = 8;
  localparam int NU  = 2;
  localparam logic [31:0] IDV = 32'h1000_0001;
`ifdef JTAG_IDCODE_EN
  localparam logic [3:0] IR_DEF = 4'h1;
`else
  localparam logic [3:0] IR_DEF = 4'hF;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tck = 1'b0;
  logic tms = 1'b1;
  logic tdi = 1'b0;
  logic tdo;
  logic tdo_oe;
  logic [NU*DRW-1:0] user_dr_in = '0;
  logic [NU*DRW-1:0] user_dr_out;
  logic [NU-1:0]     user_update;
  logic [3:0]        tap_state;
  logic [IRW-1:0]    ir_out;

  int vectors = 0;
  int miscompares = 0;
  bit exp_q[$];
  int upd_cnt = 0;
  logic [NU-1:0] upd_last = '0;

  jtag_tap_multi_dr #(
    .IR_WIDTH(IRW), .DR_WIDTH(DRW),
    .NUM_USER_DR(NU), .IDCODE_VAL(IDV)
  ) dut (
    .clk(clk), .rst(rst), .tck(tck), .tms(tms), .tdi(tdi),
    .tdo(tdo), .tdo_oe(tdo_oe),
    .user_dr_in(user_dr_in), .user_dr_out(user_dr_out),
    .user_update(user_update), .tap_state(tap_state),
    .ir_out(ir_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (user_update != '0) begin
      upd_cnt++;
      upd_last = user_update;
    end
  end

  // one TCK period; returns tdo as seen just before the rising edge
  task automatic tck_cycle(input bit m, input bit d, output bit s);
    tms = m;
    tdi = d;
    #40;
    s = tdo;
    tck = 1'b1;
    #40;
    tck = 1'b0;
  endtask

  task automatic step(input bit m);
    bit s;
    tck_cycle(m, 1'b0, s);
  endtask

  task automatic shift(input int n, input logic [63:0] data,
                       input bit ex, output logic [63:0] got);
    bit s;
    got = '0;
    for (int i = 0; i < n; i++) begin
      tck_cycle(ex && (i == n - 1), data[i], s);
      got[i] = s;
    end
  endtask

  task automatic goto_shdr_from_rti();
    step(1'b1);
    step(1'b0);
    step(1'b0);
  endtask

  task automatic load_ir(input logic [IRW-1:0] v);
    logic [63:0] g;
    step(1'b1);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    shift(IRW, 64'(v), 1'b1, g);
    step(1'b1);
    step(1'b0);
  endtask

  task automatic test_reset();
    #22;
    vectors++;
    if (tap_state !== 4'hF) begin
      miscompares++;
      $display("FAIL rst_state got %h exp F", tap_state);
    end
    vectors++;
    if (ir_out !== IR_DEF) begin
      miscompares++;
      $display("FAIL rst_ir got %h exp %h", ir_out, IR_DEF);
    end
    vectors++;
    if (tdo !== 1'b0 || tdo_oe !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_tdo got %b%b exp 00", tdo, tdo_oe);
    end
    vectors++;
    if (user_dr_out !== '0 || user_update !== '0) begin
      miscompares++;
      $display("FAIL rst_user got %h/%b exp 0/0",
               user_dr_out, user_update);
    end
    rst = 1'b0;
    #40;
  endtask

  task automatic test_idcode();
    logic [31:0] p;
    logic [63:0] g;
    bit e;
    p = 32'hC3A5_5A3C;
    step(1'b0);
    goto_shdr_from_rti();
    #40;
    vectors++;
    if (tdo_oe !== 1'b1) begin
      miscompares++;
      $display("FAIL idcode_oe got %b exp 1", tdo_oe);
    end
    for (int i = 0; i < 32; i++) begin
`ifdef JTAG_IDCODE_EN
      exp_q.push_back(IDV[i]);
`else
      exp_q.push_back(i == 0 ? 1'b0 : p[i-1]);
`endif
    end
    shift(32, 64'(p), 1'b1, g);
    for (int i = 0; i < 32; i++) begin
      e = exp_q.pop_front();
      vectors++;
      if (g[i] !== e) begin
        miscompares++;
        $display("FAIL idcode_bit%0d got %b exp %b", i, g[i], e);
      end
    end
    step(1'b1);
    step(1'b0);
  endtask

  task automatic test_bypass(input logic [IRW-1:0] code);
    logic [63:0] g;
    logic [4:0] expv;
    bit e;
    expv = 5'b11010;
    load_ir(code);
    vectors++;
    if (ir_out !== code) begin
      miscompares++;
      $display("FAIL byp_ir got %h exp %h", ir_out, code);
    end
    goto_shdr_from_rti();
    for (int i = 0; i < 5; i++) exp_q.push_back(expv[i]);
    shift(5, 64'b01101, 1'b1, g);
    for (int i = 0; i < 5; i++) begin
      e = exp_q.pop_front();
      vectors++;
      if (g[i] !== e) begin
        miscompares++;
        $display("FAIL byp%h_bit%0d got %b exp %b",
                 code, i, g[i], e);
      end
    end
    step(1'b1);
    step(1'b0);
  endtask

  task automatic user_scan(input logic [IRW-1:0] code,
                           input logic [7:0] cap,
                           input logic [7:0] din,
                           input logic [NU-1:0] exp_upd,
                           input logic [15:0] exp_out);
    logic [63:0] g;
    bit e;
    load_ir(code);
    goto_shdr_from_rti();
    user_dr_in = user_dr_in ^ 16'hFFFF;
    for (int i = 0; i < 8; i++) exp_q.push_back(cap[i]);
    shift(8, 64'(din), 1'b1, g);
    upd_cnt = 0;
    step(1'b1);
    step(1'b0);
    #40;
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      vectors++;
      if (g[i] !== e) begin
        miscompares++;
        $display("FAIL user%h_bit%0d got %b exp %b",
                 code, i, g[i], e);
      end
    end
    vectors++;
    if (upd_cnt != 1 || upd_last !== exp_upd) begin
      miscompares++;
      $display("FAIL user%h_upd got %0d/%b exp 1/%b",
               code, upd_cnt, upd_last, exp_upd);
    end
    vectors++;
    if (user_dr_out !== exp_out) begin
      miscompares++;
      $display("FAIL user%h_out got %h exp %h",
               code, user_dr_out, exp_out);
    end
  endtask

  task automatic test_user();
    user_dr_in = {8'h77, 8'h3C};
    user_scan(4'h3, 8'h77, 8'h5A, 2'b10, 16'h5A00);
    user_dr_in = {8'h77, 8'h3C};
    user_scan(4'h2, 8'h3C, 8'hA5, 2'b01, 16'h5AA5);
  endtask

  task automatic test_tlr();
    load_ir(4'hF);
    goto_shdr_from_rti();
    upd_cnt = 0;
    for (int i = 0; i < 5; i++) step(1'b1);
    #40;
    vectors++;
    if (tap_state !== 4'hF) begin
      miscompares++;
      $display("FAIL tlr_state got %h exp F", tap_state);
    end
    vectors++;
    if (ir_out !== IR_DEF || tdo_oe !== 1'b0) begin
      miscompares++;
      $display("FAIL tlr_ir_oe got %h/%b exp %h/0",
               ir_out, tdo_oe, IR_DEF);
    end
    vectors++;
    if (user_dr_out !== 16'h5AA5 || upd_cnt != 0) begin
      miscompares++;
      $display("FAIL tlr_user got %h/%0d exp 5aa5/0",
               user_dr_out, upd_cnt);
    end
  endtask

  task automatic test_rst_mid();
    logic [63:0] g;
    step(1'b0);
    load_ir(4'h3);
    goto_shdr_from_rti();
    upd_cnt = 0;
    shift(4, 64'hA, 1'b0, g);
    #20;
    rst = 1'b1;
    #30;
    rst = 1'b0;
    #40;
    vectors++;
    if (upd_cnt != 0 || user_dr_out !== '0) begin
      miscompares++;
      $display("FAIL rstmid_user got %0d/%h exp 0/0",
               upd_cnt, user_dr_out);
    end
    vectors++;
    if (tap_state !== 4'hF || ir_out !== IR_DEF) begin
      miscompares++;
      $display("FAIL rstmid_state got %h/%h exp F/%h",
               tap_state, ir_out, IR_DEF);
    end
  endtask

  task automatic test_capture_ir();
    logic [63:0] g;
    logic [3:0] expv;
    bit e;
    expv = 4'b0001;
    step(1'b0);
    step(1'b1);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    for (int i = 0; i < 4; i++) exp_q.push_back(expv[i]);
    shift(4, 64'hF, 1'b1, g);
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      vectors++;
      if (g[i] !== e) begin
        miscompares++;
        $display("FAIL capir_bit%0d got %b exp %b", i, g[i], e);
      end
    end
    step(1'b1);
    step(1'b0);
    vectors++;
    if (ir_out !== 4'hF) begin
      miscompares++;
      $display("FAIL capir_ir got %h exp F", ir_out);
    end
  endtask

  initial begin
    test_reset();
    test_idcode();
    test_bypass(4'hF);
    test_bypass(4'h7);
    test_user();
    test_tlr();
    test_rst_mid();
    test_capture_ir();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
